// File: rtl/spi_pingpong_ctrl_pkg.sv
// rtl/spi_pingpong_ctrl_pkg.sv - shared types and constants for the SPI ping-pong write sequencer
package spi_pp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    DONE = 3'd3,
    SWAP = 3'd4
  } state_e;

  localparam int WORD_W     = 16;
  localparam int BYTE_W     = 8;
  localparam int DEF_WORDS  = 128;
  localparam int DEF_ADDR_W = 7;

endpackage

// File: rtl/spi_pingpong_ctrl_if.sv
// rtl/spi_pingpong_ctrl_if.sv - byte input and RAM port-A write bundle of the sequencer
interface spi_pingpong_ctrl_if
  import spi_pp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              byte_received;
  logic [BYTE_W-1:0] received_data;
  logic              readya;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [WORD_W-1:0] dina;
  logic              finisha;

  modport master (
    input  byte_received,
    input  received_data,
    input  readya,
    output wea,
    output addra,
    output dina,
    output finisha
  );

  modport slave (
    output byte_received,
    output received_data,
    output readya,
    input  wea,
    input  addra,
    input  dina,
    input  finisha
  );

endinterface

// File: rtl/spi_pingpong_ctrl_sync_edge.sv
// rtl/spi_pingpong_ctrl_sync_edge.sv - 2-flop synchronizer with registered rise/fall pulses, idles high
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // level is taken one flop late so it changes in the same cycle as the pulse
  assign level = s3_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_pingpong_ctrl.sv
// rtl/spi_pingpong_ctrl.sv - packs SPI bytes MSB-first into 16-bit words and fills ping-pong RAM banks
module spi_pingpong_ctrl
  import spi_pp_pkg::*;
#(
  parameter int WORDS         = DEF_WORDS,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter bit FLUSH_ON_SSEL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ssel,
  spi_pingpong_ctrl_if.master bus,
  output logic [ADDR_W:0]     fill_level,
  output logic                overflow,
  output logic [7:0]          drop_cnt
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(WORDS - 1);

  logic ssel_lvl, frame_start, frame_end;
  logic in_frame, byte_v;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [WORD_W-1:0] dina_q, dina_d;
  logic              fin_q, fin_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        drop_q, drop_d;
  logic              swap1_q, swap1_d;

  sync_edge u_ssel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ssel),
    .level (ssel_lvl),
    .rise  (frame_end),
    .fall  (frame_start)
  );

  assign in_frame = ~ssel_lvl;
  // a byte landing with the deselect edge still belongs to the frame
  assign byte_v   = bus.byte_received & (in_frame | frame_end);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    fill_d  = fill_q;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    fin_d   = 1'b0;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    swap1_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          if (bus.readya) begin
            state_d = HI;
          end else begin
            state_d = SWAP;
            swap1_d = 1'b1;
          end
        end
      end
      HI: begin
        if (byte_v) begin
          hi_d    = bus.received_data;
          state_d = LO;
        end
        if (frame_end) begin
          state_d = (FLUSH_ON_SSEL && fill_q != '0) ? DONE : IDLE;
        end
      end
      LO: begin
        if (byte_v) begin
          wea_d   = 1'b1;
          addra_d = fill_q[ADDR_W-1:0];
          dina_d  = {hi_q, bus.received_data};
          fill_d  = fill_q + 1'b1;
          state_d = (fill_q == LAST) ? DONE : HI;
        end
        // a full bank and a frame end together collapse into one DONE
        if (frame_end && state_d != DONE) begin
          state_d = (FLUSH_ON_SSEL && fill_d != '0) ? DONE : IDLE;
        end
      end
      DONE: begin
        fin_d   = 1'b1;
        fill_d  = '0;
        state_d = SWAP;
        swap1_d = 1'b1;
      end
      SWAP: begin
        // readya may still show the bank we just finished, so skip one cycle
        if (!swap1_q && bus.readya) begin
          state_d = in_frame ? HI : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (byte_v && (state_q == DONE || state_q == SWAP)) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      fill_q  <= '0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      fin_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      swap1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      fill_q  <= fill_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      fin_q   <= fin_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      swap1_q <= swap1_d;
    end
  end

  assign bus.wea     = wea_q;
  assign bus.addra   = addra_q;
  assign bus.dina    = dina_q;
  assign bus.finisha = fin_q;
  assign fill_level  = fill_q;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_spi_pingpong_ctrl.sv
// tb/tb_spi_pingpong_ctrl.sv - bench for spi_pingpong_ctrl, flush-off and flush-on instances side by side
module tb_spi_pingpong_ctrl;
  import spi_pp_pkg::*;

  localparam int WORDS = 128;
  localparam int AW    = 7;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ssel   = 1'b1;
  logic       byte_r = 1'b0;
  logic       readya = 1'b1;
  logic [7:0] rdata  = 8'h00;

  always #5 clk = ~clk;

  spi_pingpong_ctrl_if #(.ADDR_W(AW)) bus0 ();
  spi_pingpong_ctrl_if #(.ADDR_W(AW)) bus1 ();

  assign bus0.byte_received = byte_r;
  assign bus0.received_data = rdata;
  assign bus0.readya        = readya;
  assign bus1.byte_received = byte_r;
  assign bus1.received_data = rdata;
  assign bus1.readya        = readya;

  logic [AW:0] fill0, fill1;
  logic        ovf0, ovf1;
  logic [7:0]  drop0, drop1;

  spi_pingpong_ctrl #(.WORDS(WORDS), .ADDR_W(AW), .FLUSH_ON_SSEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ssel(ssel), .bus(bus0),
    .fill_level(fill0), .overflow(ovf0), .drop_cnt(drop0));

  spi_pingpong_ctrl #(.WORDS(WORDS), .ADDR_W(AW), .FLUSH_ON_SSEL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ssel(ssel), .bus(bus1),
    .fill_level(fill1), .overflow(ovf1), .drop_cnt(drop1));

  logic        wea_a [2];
  logic        fin_a [2];
  logic [22:0] wd_a  [2];
  logic [AW:0] fill_a[2];
  logic        ovf_a [2];
  logic [7:0]  drop_a[2];

  assign wea_a[0]  = bus0.wea;
  assign wea_a[1]  = bus1.wea;
  assign fin_a[0]  = bus0.finisha;
  assign fin_a[1]  = bus1.finisha;
  assign wd_a[0]   = {bus0.addra, bus0.dina};
  assign wd_a[1]   = {bus1.addra, bus1.dina};
  assign fill_a[0] = fill0;
  assign fill_a[1] = fill1;
  assign ovf_a[0]  = ovf0;
  assign ovf_a[1]  = ovf1;
  assign drop_a[0] = drop0;
  assign drop_a[1] = drop1;

  int total = 0;
  int bad   = 0;

  // reference model: bank fill, pending high byte, waiting for a free bank
  bit          flush_cfg[2] = '{1'b0, 1'b1};
  int          m_fill[2];
  bit          m_half[2];
  logic [7:0]  m_hi[2];
  bit          m_wait[2];
  int          exp_fin[2];
  int          exp_drop[2];
  bit          exp_ovf[2];
  logic [22:0] exp_q[2][$];

  logic [22:0] act_q[2][$];
  int          act_fin[2];
  int          last_wr[2];
  int          fin_cyc[2];
  logic [22:0] prev_wd[2];
  int          both_err = 0;
  int          hold_err = 0;
  int          cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (wea_a[d]) begin
          act_q[d].push_back(wd_a[d]);
          last_wr[d] = cyc;
        end
        if (fin_a[d]) begin
          act_fin[d]++;
          fin_cyc[d] = cyc;
        end
        if (wea_a[d] && fin_a[d]) both_err++;
        if (rst_n && !wea_a[d] && wd_a[d] !== prev_wd[d]) hold_err++;
        prev_wd[d] = wd_a[d];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_fill[d] = 0; m_half[d] = 0; m_hi[d] = 8'h00; m_wait[d] = 0;
      exp_fin[d] = 0; exp_drop[d] = 0; exp_ovf[d] = 0;
      exp_q[d].delete(); act_q[d].delete();
      act_fin[d] = 0; last_wr[d] = -1; fin_cyc[d] = -1;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ssel   = 1'b1;
    byte_r = 1'b0;
    readya = 1'b1;
    repeat (3) tick();
    model_clear();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic model_start();
    for (int d = 0; d < 2; d++) begin
      if (m_wait[d] && readya) m_wait[d] = 0;
      if (!m_wait[d] && !readya) m_wait[d] = 1;
      m_half[d] = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    for (int d = 0; d < 2; d++) begin
      if (m_wait[d] && readya) begin
        m_wait[d] = 0;
        m_half[d] = 0;
      end
      if (m_wait[d]) begin
        exp_ovf[d] = 1;
        if (exp_drop[d] < 255) exp_drop[d]++;
      end else if (!m_half[d]) begin
        m_hi[d]   = b;
        m_half[d] = 1;
      end else begin
        exp_q[d].push_back({AW'(m_fill[d]), m_hi[d], b});
        m_fill[d]++;
        m_half[d] = 0;
        if (m_fill[d] == WORDS) begin
          exp_fin[d]++;
          m_fill[d] = 0;
          m_wait[d] = 1;
        end
      end
    end
  endtask

  task automatic model_end();
    for (int d = 0; d < 2; d++) begin
      m_half[d] = 0;
      if (!m_wait[d] && flush_cfg[d] && m_fill[d] > 0) begin
        exp_fin[d]++;
        m_fill[d] = 0;
        m_wait[d] = 1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rdata  = b;
    byte_r = 1'b1;
    model_byte(b);
    tick();
    byte_r = 1'b0;
    rdata  = 8'($urandom);
    repeat (gap - 1) tick();
  endtask

  task automatic frame_begin();
    ssel = 1'b0;
    model_start();
    repeat (6) tick();
  endtask

  // coincide puts a byte in the exact cycle the frame-end edge reaches the FSM
  task automatic frame_end(input bit coincide, input logic [7:0] b);
    ssel = 1'b1;
    repeat (3) tick();
    if (coincide) begin
      rdata  = b;
      byte_r = 1'b1;
      model_byte(b);
      tick();
      byte_r = 1'b0;
    end
    model_end();
    repeat (10) tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({wea_a[d], fin_a[d], wd_a[d], fill_a[d], ovf_a[d], drop_a[d]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d wea=%b fin=%b wd=%h fill=%0d ovf=%b drop=%0d want all 0",
                 d, wea_a[d], fin_a[d], wd_a[d], fill_a[d], ovf_a[d], drop_a[d]);
      end
    end
  endtask

  task automatic test_single_word();
    do_reset();
    frame_begin();
    send_byte(8'hA5, 6);
    send_byte(8'h3C, 6);
    frame_end(1'b0, 8'h00);
    total++;
    if (act_q[0].size() != 1 || act_q[0][0] !== {7'd0, 16'hA53C}) begin
      bad++;
      $display("FAIL single_word dut0 writes=%0d first=%h want 1 x %h", act_q[0].size(),
               act_q[0].size() > 0 ? act_q[0][0] : 23'h0, {7'd0, 16'hA53C});
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (act_fin[d] != exp_fin[d] || int'(fill_a[d]) != m_fill[d]) begin
        bad++;
        $display("FAIL single_word_state dut%0d fin=%0d fill=%0d want fin=%0d fill=%0d",
                 d, act_fin[d], fill_a[d], exp_fin[d], m_fill[d]);
      end
    end
  endtask

  task automatic test_full_bank();
    do_reset();
    frame_begin();
    for (int i = 0; i < 255; i++) send_byte(8'(i), 6);
    send_byte(8'hFF, 1);
    readya = 1'b0;
    repeat (8) tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (act_q[d].size() != WORDS) begin
        bad++;
        $display("FAIL full_bank_count dut%0d got=%0d want=%0d", d, act_q[d].size(), WORDS);
      end else begin
        for (int k = 0; k < WORDS; k++) begin
          total++;
          if (act_q[d][k] !== exp_q[d][k]) begin
            bad++;
            $display("FAIL full_bank_word dut%0d k=%0d got=%h want=%h", d, k, act_q[d][k], exp_q[d][k]);
          end
        end
      end
      total++;
      if (act_fin[d] != 1 || fin_cyc[d] != last_wr[d] + 1 || fill_a[d] !== '0) begin
        bad++;
        $display("FAIL full_bank_finish dut%0d fin=%0d fin_cyc=%0d last_wr=%0d fill=%0d want 1 at last_wr+1 fill 0",
                 d, act_fin[d], fin_cyc[d], last_wr[d], fill_a[d]);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 6);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (act_q[d].size() != WORDS || ovf_a[d] !== 1'b1 || int'(drop_a[d]) != 4) begin
        bad++;
        $display("FAIL overflow_drop dut%0d writes=%0d ovf=%b drop=%0d want %0d/1/4",
                 d, act_q[d].size(), ovf_a[d], drop_a[d], WORDS);
      end
    end
    readya = 1'b1;
    repeat (6) tick();
    send_byte(8'h11, 6);
    send_byte(8'h22, 6);
    frame_end(1'b0, 8'h00);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (act_q[d].size() != WORDS + 1 || act_q[d][$] !== {7'd0, 16'h1122}) begin
        bad++;
        $display("FAIL overflow_resume dut%0d writes=%0d last=%h want %0d and %h", d, act_q[d].size(),
                 act_q[d].size() > 0 ? act_q[d][$] : 23'h0, WORDS + 1, {7'd0, 16'h1122});
      end
      total++;
      if (int'(drop_a[d]) != exp_drop[d] || act_fin[d] != exp_fin[d]) begin
        bad++;
        $display("FAIL overflow_model dut%0d drop=%0d fin=%0d want %0d/%0d", d, drop_a[d], act_fin[d],
                 exp_drop[d], exp_fin[d]);
      end
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    readya = 1'b0;
    repeat (4) tick();
    frame_begin();
    for (int i = 0; i < 258; i++) send_byte(8'($urandom), 2);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (int'(drop_a[d]) != exp_drop[d] || drop_a[d] !== 8'd255 || act_q[d].size() != 0) begin
        bad++;
        $display("FAIL drop_saturate dut%0d drop=%0d writes=%0d want 255/0", d, drop_a[d], act_q[d].size());
      end
    end
    frame_end(1'b0, 8'h00);
  endtask

  task automatic test_odd_frame();
    do_reset();
    frame_begin();
    send_byte(8'h01, 6);
    send_byte(8'h02, 6);
    send_byte(8'h03, 6);
    frame_end(1'b0, 8'h00);
    total++;
    if (act_q[0].size() != 1 || act_q[0][0] !== {7'd0, 16'h0102} || drop_a[0] !== 8'd0 ||
        act_fin[0] != 0 || fill_a[0] !== 8'd1) begin
      bad++;
      $display("FAIL odd_frame dut0 writes=%0d drop=%0d fin=%0d fill=%0d want 1 write 0102, 0, 0, 1",
               act_q[0].size(), drop_a[0], act_fin[0], fill_a[0]);
    end
    total++;
    if (act_q[1].size() != 1 || act_fin[1] != 1 || fill_a[1] !== 8'd0) begin
      bad++;
      $display("FAIL odd_frame_flush dut1 writes=%0d fin=%0d fill=%0d want 1/1/0",
               act_q[1].size(), act_fin[1], fill_a[1]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    frame_begin();
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 6);
    frame_end(1'b0, 8'h00);
    total++;
    if (act_q[1].size() != 5 || act_fin[1] != 1 || fin_cyc[1] <= last_wr[1]) begin
      bad++;
      $display("FAIL flush dut1 writes=%0d fin=%0d fin_cyc=%0d last_wr=%0d want 5 writes then 1 finish",
               act_q[1].size(), act_fin[1], fin_cyc[1], last_wr[1]);
    end
    total++;
    if (act_q[0].size() != 5 || act_fin[0] != 0) begin
      bad++;
      $display("FAIL flush_off dut0 writes=%0d fin=%0d want 5/0", act_q[0].size(), act_fin[0]);
    end
    frame_begin();
    send_byte(8'h5A, 6);
    send_byte(8'hC3, 6);
    frame_end(1'b0, 8'h00);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (act_q[d].size() != exp_q[d].size() || act_q[d][$] !== exp_q[d][$]) begin
        bad++;
        $display("FAIL flush_next dut%0d writes=%0d last=%h want %0d and %h", d, act_q[d].size(),
                 act_q[d][$], exp_q[d].size(), exp_q[d][$]);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    frame_begin();
    send_byte(8'hDE, 6);
    send_byte(8'hAD, 6);
    send_byte(8'hBE, 6);
    frame_end(1'b1, 8'hEF);
    total++;
    if (act_q[0].size() != 2 || act_q[0][1] !== {7'd1, 16'hBEEF}) begin
      bad++;
      $display("FAIL simultaneous dut0 writes=%0d second=%h want 2 and %h", act_q[0].size(),
               act_q[0].size() > 1 ? act_q[0][1] : 23'h0, {7'd1, 16'hBEEF});
    end
    total++;
    if (act_fin[1] != 1 || act_q[1].size() != 2) begin
      bad++;
      $display("FAIL simultaneous_flush dut1 fin=%0d writes=%0d want 1/2", act_fin[1], act_q[1].size());
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    frame_begin();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 6);
    rst_n = 1'b0;
    ssel  = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({wea_a[d], fin_a[d], wd_a[d], fill_a[d], ovf_a[d], drop_a[d]} !== '0) begin
        bad++;
        $display("FAIL reset_midframe dut%0d wd=%h fill=%0d fin=%b want all 0", d, wd_a[d], fill_a[d], fin_a[d]);
      end
    end
    do_reset();
    frame_begin();
    send_byte(8'h77, 6);
    send_byte(8'h88, 6);
    frame_end(1'b0, 8'h00);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (act_q[d].size() != 1 || act_q[d][0] !== {7'd0, 16'h7788} || act_fin[d] != exp_fin[d]) begin
        bad++;
        $display("FAIL reset_restart dut%0d writes=%0d fin=%0d want 1 write at 0 of 7788, fin %0d",
                 d, act_q[d].size(), act_fin[d], exp_fin[d]);
      end
    end
  endtask

  task automatic test_random_frames();
    do_reset();
    for (int f = 0; f < 14; f++) begin
      readya = ($urandom_range(0, 3) != 0);
      repeat (4) tick();
      frame_begin();
      for (int i = 0, n = $urandom_range(0, 24); i < n; i++) send_byte(8'($urandom), $urandom_range(6, 9));
      frame_end(bit'($urandom_range(0, 1)), 8'($urandom));
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (act_q[d].size() != exp_q[d].size()) begin
        bad++;
        $display("FAIL random_count dut%0d got=%0d want=%0d", d, act_q[d].size(), exp_q[d].size());
      end else begin
        for (int k = 0; k < exp_q[d].size(); k++) begin
          total++;
          if (act_q[d][k] !== exp_q[d][k]) begin
            bad++;
            $display("FAIL random_word dut%0d k=%0d got=%h want=%h", d, k, act_q[d][k], exp_q[d][k]);
          end
        end
      end
      total++;
      if (act_fin[d] != exp_fin[d] || int'(fill_a[d]) != m_fill[d] || int'(drop_a[d]) != exp_drop[d] ||
          ovf_a[d] !== exp_ovf[d]) begin
        bad++;
        $display("FAIL random_state dut%0d fin=%0d fill=%0d drop=%0d ovf=%b want %0d/%0d/%0d/%b",
                 d, act_fin[d], fill_a[d], drop_a[d], ovf_a[d], exp_fin[d], m_fill[d], exp_drop[d], exp_ovf[d]);
      end
    end
  endtask

  task automatic test_invariants();
    total++;
    if (both_err != 0) begin
      bad++;
      $display("FAIL wea_finisha_overlap count=%0d want 0", both_err);
    end
    total++;
    if (hold_err != 0) begin
      bad++;
      $display("FAIL addr_data_hold changes=%0d want 0", hold_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_bank();
    test_overflow();
    test_drop_saturate();
    test_odd_frame();
    test_flush();
    test_simultaneous();
    test_reset_midframe();
    test_random_frames();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
